// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer front end.
// Optional feature macro: SER_PARITY_EN adds the PARITY state.
package ser_pkg;

   localparam int SER_DATA_W = 8;
   localparam int SER_DIV_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1
`ifdef SER_PARITY_EN
      ,
      ST_PARITY = 2'd2
`endif
   } ser_state_e;

endpackage

// File: rtl/ser_div_cnt.sv
// Bit-period counter: counts 0..period_i, wraps on bit end.
// Ports: clk, rst_n, en_i, load_i, period_i -> bit_end_o, bit_start_o.
module ser_div_cnt #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] period_i,
   output logic             bit_end_o,
   output logic             bit_start_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign bit_end_o   = (cnt_q == period_i);
   assign bit_start_o = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || load_i || bit_end_o)
         cnt_d = '0;
      else
         cnt_d = cnt_q + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with one-word holding buffer.
// In: clk, rst_n, cfg_div, cfg_msb_first, in_valid, in_data.
// Out: in_ready, x_out, x_vld, x_stb, busy.
// Optional: SER_PARITY_EN appends an even-parity bit per word.
import ser_pkg::*;

module bit_serializer #(
   parameter int DATA_W = SER_DATA_W,
   parameter int DIV_W  = SER_DIV_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_msb_first,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              x_out,
   output logic              x_vld,
   output logic              x_stb,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   ser_state_e        state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  bit_q, bit_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              full_q, full_d;
`ifdef SER_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              accept;
   logic              load;
   logic              fin;
   logic              bit_end;
   logic              bit_start;
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] rev;

   assign accept = in_valid && !full_q;

   ser_div_cnt #(
      .DIV_W(DIV_W)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (state_q != ST_IDLE),
      .load_i     (load),
      .period_i   (div_q),
      .bit_end_o  (bit_end),
      .bit_start_o(bit_start)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      div_d   = div_q;
      hold_d  = hold_q;
      full_d  = full_q;
`ifdef SER_PARITY_EN
      par_d   = par_q;
`endif
      load    = 1'b0;
      fin     = 1'b0;
      word    = in_data;
      rev     = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept)
               load = 1'b1;
         end
         ST_SHIFT: begin
            if (bit_end) begin
               if (bit_q == LAST) begin
`ifdef SER_PARITY_EN
                  state_d = ST_PARITY;
`else
                  fin = 1'b1;
`endif
               end else begin
                  sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                  bit_d = bit_q + CNT_W'(1);
               end
            end
         end
`ifdef SER_PARITY_EN
         ST_PARITY: begin
            if (bit_end)
               fin = 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Final clock of a word: reload from holding, else take a
      // handshake straight into the shifter, else fall idle.
      if (fin) begin
         if (full_q) begin
            load   = 1'b1;
            word   = hold_q;
            full_d = 1'b0;
         end else if (accept) begin
            load = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (state_q != ST_IDLE && accept) begin
         hold_d = in_data;
         full_d = 1'b1;
      end

      for (int i = 0; i < DATA_W; i++)
         rev[i] = word[DATA_W-1-i];

      // Shifter always emits its MSB; LSB-first words are stored
      // reversed so one shift direction serves both orders.
      if (load) begin
         state_d = ST_SHIFT;
         sh_d    = cfg_msb_first ? word : rev;
         bit_d   = '0;
         div_d   = cfg_div;
`ifdef SER_PARITY_EN
         par_d   = ^word;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         hold_q  <= '0;
         full_q  <= 1'b0;
`ifdef SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
`ifdef SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign x_vld    = (state_q != ST_IDLE);
   assign x_stb    = x_vld && bit_start;
   assign in_ready = !full_q;
   assign busy     = x_vld || full_q;
`ifdef SER_PARITY_EN
   assign x_out = ((state_q == ST_SHIFT) && sh_q[DATA_W-1]) ||
                  ((state_q == ST_PARITY) && par_q);
`else
   assign x_out = (state_q == ST_SHIFT) && sh_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: per-cycle sample-stream
// model plus directed literal checks and randomized bursts.
module tb_bit_serializer;

   localparam int DW = 8;
   localparam int VW = 8;
`ifdef SER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [VW-1:0] cfg_div = '0;
   logic          cfg_msb_first = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, x_out, x_vld, x_stb, busy;

   bit_serializer #(.DATA_W(DW), .DIV_W(VW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_div      (cfg_div),
      .cfg_msb_first(cfg_msb_first),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .x_out        (x_out),
      .x_vld        (x_vld),
      .x_stb        (x_stb),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic vld;
      logic stb;
      logic x;
      logic first;
   } samp_t;

   samp_t exp_q[$];
   int    waiting = 0;
   logic  exp_ready = 1'b1;
   int    n_tests = 0;
   int    n_fail = 0;

   logic [31:0] cap;
   int          vld_cnt, stb_cnt, run, max_run;
   logic        saw_nr;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
      end
   endtask

   // Every accepted word becomes its full per-clock output sequence,
   // queued behind whatever is still to be emitted.
   function automatic void expand(input logic [DW-1:0] w, input int div,
                                  input logic msb);
      samp_t s;
      int idx;
      for (int b = 0; b < DW; b++) begin
         idx = msb ? DW - 1 - b : b;
         for (int c = 0; c <= div; c++) begin
            s.vld   = 1'b1;
            s.stb   = (c == 0);
            s.x     = w[idx];
            s.first = (b == 0 && c == 0);
            exp_q.push_back(s);
         end
      end
`ifdef SER_PARITY_EN
      for (int c = 0; c <= div; c++) begin
         s.vld   = 1'b1;
         s.stb   = (c == 0);
         s.x     = ^w;
         s.first = 1'b0;
         exp_q.push_back(s);
      end
`endif
   endfunction

   always @(posedge clk) begin
      if (rst_n && in_valid && exp_ready) begin
         expand(in_data, int'(cfg_div), cfg_msb_first);
         waiting++;
      end
   end

   always @(negedge clk) begin
      samp_t s;
      logic  busy_e;
      s = '0;
      if (!rst_n) begin
         exp_q.delete();
         waiting = 0;
      end else if (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         if (s.first)
            waiting--;
      end
      exp_ready = (waiting == 0);
      busy_e = s.vld || (waiting > 0);
      check("cycle{x,vld,stb,busy,rdy}",
            32'({x_out, x_vld, x_stb, busy, in_ready}),
            32'({s.x, s.vld, s.stb, busy_e, exp_ready}));
      if (x_vld) begin
         cap = {cap[30:0], x_out};
         vld_cnt++;
         if (x_stb)
            stb_cnt++;
         run++;
         if (run > max_run)
            max_run = run;
      end else begin
         run = 0;
      end
      if (rst_n && !in_ready)
         saw_nr = 1'b1;
   end

   task automatic clr_mon();
      cap = '0;
      vld_cnt = 0;
      stb_cnt = 0;
      max_run = 0;
      saw_nr = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] w);
      in_valid = 1'b1;
      in_data = w;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         #1;
         if (exp_ready)
            break;
         if (t > 5000) begin
            check("send_timeout", 32'(1), 32'(0));
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; ; t++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && waiting == 0)
            break;
         if (t > 20000) begin
            check("idle_timeout", 32'(1), 32'(0));
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic int count101(input logic [31:0] v, input int n);
      int k;
      k = 0;
      for (int i = 0; i + 3 <= n; i++)
         if (v[i+:3] == 3'b101)
            k++;
      return k;
   endfunction

   initial begin
      logic [31:0] sh;
      int nw;
      clr_mon();
      run = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            32'({x_out, x_vld, x_stb, busy, in_ready}), 32'(5'b00001));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cfg_div = 0;
      cfg_msb_first = 1'b1;
      clr_mon();
      send(8'hA5);
      wait_idle();
      sh = cap >> PB;
      check("a5_bits", 32'(sh[7:0]), 32'(8'hA5));
      check("a5_vld_cycles", 32'(vld_cnt), 32'(8 + PB));
      check("a5_stb_cycles", 32'(stb_cnt), 32'(8 + PB));
      check("a5_busy_after", 32'(busy), 32'(0));

      clr_mon();
      send(8'h05);
      send(8'h00);
      wait_idle();
      check("b2b_vld_cycles", 32'(vld_cnt), 32'(16 + 2 * PB));
      check("b2b_no_gap", 32'(max_run), 32'(16 + 2 * PB));
      check("b2b_ready_drop", 32'(saw_nr), 32'(1));
      check("b2b_one_101", 32'(count101(cap, vld_cnt)), 32'(1));

      clr_mon();
      cfg_div = 2;
      send(8'hFF);
      repeat (4) @(posedge clk);
      #1;
      cfg_div = 0;
      wait_idle();
      check("div2_vld_cycles", 32'(vld_cnt), 32'(24 + 3 * PB));
      check("div2_stb_count", 32'(stb_cnt), 32'(8 + PB));
      check("div2_contiguous", 32'(max_run), 32'(24 + 3 * PB));

      clr_mon();
      cfg_msb_first = 1'b0;
      send(8'h01);
      wait_idle();
      sh = cap >> PB;
      check("lsb_first_01", 32'(sh[7:0]), 32'(8'h80));

      cfg_msb_first = 1'b1;
      send(8'hFF);
      send(8'h00);
      check("hold_full_ready", 32'(in_ready), 32'(0));
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({x_out, x_vld, x_stb, busy, in_ready}), 32'(5'b00001));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clr_mon();
      send(8'hA5);
      wait_idle();
      sh = cap >> PB;
      check("post_reset_bits", 32'(sh[7:0]), 32'(8'hA5));
      check("post_reset_vld", 32'(vld_cnt), 32'(8 + PB));

`ifdef SER_PARITY_EN
      clr_mon();
      send(8'h07);
      wait_idle();
      check("parity_07", 32'(cap[8:0]), 32'({8'h07, 1'b1}));
      check("parity_07_vld", 32'(vld_cnt), 32'(9));
      clr_mon();
      send(8'h03);
      wait_idle();
      check("parity_03", 32'(cap[8:0]), 32'({8'h03, 1'b0}));
`endif

      for (int b = 0; b < 12; b++) begin
         cfg_div = (b == 5) ? 8'hFF : VW'($urandom_range(0, 3));
         cfg_msb_first = 1'($urandom_range(0, 1));
         nw = (b == 5) ? 2 : int'($urandom_range(1, 6));
         for (int w = 0; w < nw; w++) begin
            send(DW'($urandom));
            repeat ($urandom_range(0, 2) * $urandom_range(0, 6))
               @(posedge clk);
            #0;
         end
         wait_idle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
